// File: rtl/raw_scoreboard_pkg.sv
// common_def: RV32 opcode constants and source-operand usage decode for the RAW scoreboard
package common_def;
  localparam logic [6:0] LUI_opcode    = 7'b0110111;
  localparam logic [6:0] AUIPC_opcode  = 7'b0010111;
  localparam logic [6:0] JAL_opcode    = 7'b1101111;
  localparam logic [6:0] JALR_opcode   = 7'b1100111;
  localparam logic [6:0] BRANCH_opcode = 7'b1100011;
  localparam logic [6:0] LOAD_opcode   = 7'b0000011;
  localparam logic [6:0] STORE_opcode  = 7'b0100011;
  localparam logic [6:0] OP_opcode     = 7'b0110011;
  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic is_branch;
  } src_use_t;
  function automatic src_use_t decode_src(input logic [6:0] opcode);
    return '{uses_rs1:  !(opcode inside {LUI_opcode, AUIPC_opcode, JAL_opcode}),
             uses_rs2:  opcode inside {BRANCH_opcode, STORE_opcode, OP_opcode},
             is_branch: opcode inside {BRANCH_opcode, JALR_opcode}};
  endfunction
endpackage

// File: rtl/raw_scoreboard_if.sv
// raw_scoreboard_if: decode-stage issue handshake and scoreboard status bundle
interface raw_scoreboard_if #(
  parameter int NUM_REGS    = 32,
  parameter int MAX_LAT     = 4,
  parameter int STALL_CNT_W = 16,
  parameter int LAT_W       = $clog2(MAX_LAT + 1)
);
  logic                   issue_valid;
  logic [31:0]            issue_instr;
  logic                   issue_rd_we;
  logic [LAT_W-1:0]       issue_lat;
  logic                   flush;
  logic                   stall;
  logic                   issue_fire;
  logic [NUM_REGS-1:0]    busy_vec;
  logic [STALL_CNT_W-1:0] stall_cycles;
  modport master (output issue_valid, issue_instr, issue_rd_we, issue_lat, flush,
                  input  stall, issue_fire, busy_vec, stall_cycles);
  modport slave  (input  issue_valid, issue_instr, issue_rd_we, issue_lat, flush,
                  output stall, issue_fire, busy_vec, stall_cycles);
endinterface

// File: rtl/raw_scoreboard_entry.sv
// raw_sb_entry: one register's countdown (load beats decrement); LOAD_BRANCH_EXTRA_EN adds is_load tracking
module raw_sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LAT_W-1:0] lat,
`ifdef LOAD_BRANCH_EXTRA_EN
  input  logic             load_is_load,
  output logic             br_extra,
`endif
  output logic [LAT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? lat : (cnt != '0 ? cnt - LAT_W'(1) : cnt);
`ifdef LOAD_BRANCH_EXTRA_EN
  logic is_load, prev_nz;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      is_load <= 1'b0;
      prev_nz <= 1'b0;
    end else begin
      is_load <= load ? load_is_load : is_load;
      prev_nz <= |cnt;
    end
  assign br_extra = is_load & prev_nz;
`endif
endmodule

// File: rtl/raw_scoreboard.sv
// raw_scoreboard: per-register RAW countdown scoreboard with issue stall and stall counter; option LOAD_BRANCH_EXTRA_EN
module raw_scoreboard
  import common_def::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int REG_IDX_W   = $clog2(NUM_REGS),
  parameter int MAX_LAT     = 4,
  parameter int LAT_W       = $clog2(MAX_LAT + 1),
  parameter int FWD_SLACK   = 1,
  parameter int STALL_CNT_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  raw_scoreboard_if.slave sb
);
  logic [LAT_W-1:0]       cnt [NUM_REGS];
  logic [NUM_REGS-1:0]    br_extra;
  logic [6:0]             opcode;
  logic [REG_IDX_W-1:0]   rd, rs1, rs2;
  src_use_t               u;
  logic [LAT_W-1:0]       allow;
  logic                   haz1, haz2, wr;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   unused_bits;
  assign opcode      = sb.issue_instr[6:0];
  assign rd          = sb.issue_instr[7 +: REG_IDX_W];
  assign rs1         = sb.issue_instr[15 +: REG_IDX_W];
  assign rs2         = sb.issue_instr[20 +: REG_IDX_W];
  assign unused_bits = ^{sb.issue_instr[31:25], sb.issue_instr[14:12]};
  assign u           = decode_src(opcode);
  assign allow       = u.is_branch ? '0 : LAT_W'(FWD_SLACK);
  // cnt[0] is tied to zero, so x0 sources never hazard
  assign haz1 = u.uses_rs1 & ((cnt[rs1] > allow) | (u.is_branch & br_extra[rs1]));
  assign haz2 = u.uses_rs2 & ((cnt[rs2] > allow) | (u.is_branch & br_extra[rs2]));
  assign sb.stall      = rst_n & sb.issue_valid & ~sb.flush & (haz1 | haz2);
  assign sb.issue_fire = rst_n & sb.issue_valid & ~sb.flush & ~(haz1 | haz2);
  assign wr            = sb.issue_fire & sb.issue_rd_we & (rd != '0);
  assign cnt[0]         = '0;
  assign sb.busy_vec[0] = 1'b0;
`ifdef LOAD_BRANCH_EXTRA_EN
  assign br_extra[0] = 1'b0;
`else
  assign br_extra = '0;
`endif
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
    raw_sb_entry #(.LAT_W(LAT_W)) u_ent (
      .clk          (clk),
      .rst_n        (rst_n),
      .load         (wr && rd == REG_IDX_W'(r)),
      .lat          (sb.issue_lat),
`ifdef LOAD_BRANCH_EXTRA_EN
      .load_is_load (opcode == LOAD_opcode),
      .br_extra     (br_extra[r]),
`endif
      .cnt          (cnt[r])
    );
    assign sb.busy_vec[r] = |cnt[r];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (sb.stall && !(&stall_cnt)) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
  assign sb.stall_cycles = stall_cnt;
  a_lat_legal: assert property (@(posedge clk) disable iff (!rst_n) wr |-> sb.issue_lat <= LAT_W'(MAX_LAT));
endmodule

// File: tb/tb_raw_scoreboard.sv
// tb_raw_scoreboard: ready-time model checked every cycle plus directed stall-count checks
module tb_raw_scoreboard;
  localparam int NR  = 32;
  localparam int SCW = 8;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BR = 7'b1100011, LD = 7'b0000011, ST = 7'b0100011, OPR = 7'b0110011;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  raw_scoreboard_if #(.NUM_REGS(NR), .MAX_LAT(4), .STALL_CNT_W(SCW)) sb ();
  raw_scoreboard #(.NUM_REGS(NR), .MAX_LAT(4), .FWD_SLACK(1), .STALL_CNT_W(SCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb)
  );
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), op};
  endfunction
  // model: each register remembers the cycle its value becomes usable for each consumer class
  int cyc = 0;
  int done_c [NR];
  int rdy_nb [NR];
  int rdy_br [NR];
  int exp_sc = 0;
  logic [6:0] m_op;
  int m_rd, m_rs1, m_rs2, m_lat;
  logic m_u1, m_u2, m_br, m_h, m_es, m_ef;
  logic [NR-1:0] m_busy;
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NR; r++) begin
        done_c[r] = 0;
        rdy_nb[r] = 0;
        rdy_br[r] = 0;
      end
      exp_sc = 0;
      chk("reset stall", sb.stall, 0);
      chk("reset fire", sb.issue_fire, 0);
      chk("reset busy", sb.busy_vec, 0);
      chk("reset stall_cycles", sb.stall_cycles, 0);
    end else begin
      m_op  = sb.issue_instr[6:0];
      m_rd  = int'(sb.issue_instr[11:7]);
      m_rs1 = int'(sb.issue_instr[19:15]);
      m_rs2 = int'(sb.issue_instr[24:20]);
      m_lat = int'(sb.issue_lat);
      m_u1  = !(m_op == LUI || m_op == AUIPC || m_op == JAL);
      m_u2  = m_op == BR || m_op == ST || m_op == OPR;
      m_br  = m_op == BR || m_op == JALR;
      m_h   = (m_u1 && cyc < (m_br ? rdy_br[m_rs1] : rdy_nb[m_rs1])) ||
              (m_u2 && cyc < (m_br ? rdy_br[m_rs2] : rdy_nb[m_rs2]));
      m_es  = sb.issue_valid && !sb.flush && m_h;
      m_ef  = sb.issue_valid && !sb.flush && !m_h;
      for (int r = 0; r < NR; r++) m_busy[r] = cyc < done_c[r];
      chk("stall", sb.stall, m_es);
      chk("issue_fire", sb.issue_fire, m_ef);
      chk("busy_vec", sb.busy_vec, m_busy);
      chk("stall_cycles", sb.stall_cycles, exp_sc);
      if (m_es && exp_sc < (1 << SCW) - 1) exp_sc++;
      if (m_ef && sb.issue_rd_we && m_rd != 0) begin
        done_c[m_rd] = cyc + m_lat + 1;
        rdy_nb[m_rd] = cyc + m_lat;
        rdy_br[m_rd] = cyc + m_lat + 1;
`ifdef LOAD_BRANCH_EXTRA_EN
        if (m_op == LD && m_lat > 0) rdy_br[m_rd] = cyc + m_lat + 2;
`endif
      end
    end
    cyc++;
  end
  // present an instruction until it fires; waits = number of stalled cycles
  task automatic issue(input logic [31:0] ins, input logic we, input int lat, output int waits);
    waits = 0;
    sb.issue_valid = 1'b1;
    sb.issue_instr = ins;
    sb.issue_rd_we = we;
    sb.issue_lat   = 3'(lat);
    forever begin
      @(negedge clk);
      if (sb.issue_fire) break;
      waits++;
      if (waits > 20) break;
    end
    @(posedge clk);
    #1;
    sb.issue_valid = 1'b0;
    sb.issue_rd_we = 1'b0;
  endtask
  int w;
  initial begin
    sb.issue_valid = 1'b0;
    sb.issue_instr = '0;
    sb.issue_rd_we = 1'b0;
    sb.issue_lat   = '0;
    sb.flush       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init busy", sb.busy_vec, 0);
    chk("init stall_cycles", sb.stall_cycles, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(enc(OPR, 5, 0, 0), 1'b1, 2, w);
    chk("add x5 free", w, 0);
    issue(enc(BR, 0, 5, 0), 1'b0, 0, w);
    chk("beq x5 after lat2", w, 2);
    issue(enc(OPR, 5, 0, 0), 1'b1, 2, w);
    issue(enc(OPR, 6, 5, 5), 1'b1, 1, w);
    chk("add x6 x5 x5 after lat2", w, 1);
    issue(enc(OPR, 0, 0, 0), 1'b1, 4, w);
    chk("busy x0", sb.busy_vec[0], 0);
    issue(enc(BR, 0, 0, 0), 1'b0, 0, w);
    chk("beq x0", w, 0);
    issue(enc(OPR, 5, 0, 0), 1'b1, 3, w);
    issue(enc(ST, 0, 0, 5), 1'b0, 0, w);
    chk("sw rs2 x5 after lat3", w, 2);
    issue(enc(OPR, 5, 0, 0), 1'b1, 2, w);
    issue(enc(JALR, 1, 5, 0), 1'b1, 1, w);
    chk("jalr x5 after lat2", w, 2);
    issue(enc(OPR, 5, 0, 0), 1'b1, 4, w);
    issue(enc(LUI, 8, 5, 5), 1'b1, 1, w);
    chk("lui ignores rs", w, 0);
    issue(enc(JAL, 9, 5, 5), 1'b1, 1, w);
    chk("jal ignores rs", w, 0);
    issue(enc(AUIPC, 10, 5, 5), 1'b1, 1, w);
    chk("auipc ignores rs", w, 0);
    repeat (4) @(posedge clk);
    #1;
    issue(enc(LD, 7, 0, 0), 1'b1, 2, w);
    issue(enc(BR, 0, 7, 0), 1'b0, 0, w);
`ifdef LOAD_BRANCH_EXTRA_EN
    chk("bne after lw", w, 3);
`else
    chk("bne after lw", w, 2);
`endif
    issue(enc(OPR, 5, 0, 0), 1'b1, 4, w);
    sb.issue_valid = 1'b1;
    sb.issue_instr = enc(BR, 0, 5, 0);
    sb.flush       = 1'b1;
    @(negedge clk);
    chk("flush stall", sb.stall, 0);
    chk("flush fire", sb.issue_fire, 0);
    chk("flush busy x5", sb.busy_vec[5], 1);
    @(posedge clk);
    #1;
    sb.flush = 1'b0;
    issue(enc(BR, 0, 5, 0), 1'b0, 0, w);
    chk("beq after flush", w, 3);
    issue(enc(OPR, 5, 0, 0), 1'b1, 3, w);
    chk("pre-reset busy x5", sb.busy_vec[5], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun reset busy", sb.busy_vec, 0);
    chk("midrun reset stall_cycles", sb.stall_cycles, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(enc(BR, 0, 5, 0), 1'b0, 0, w);
    chk("beq after reset", w, 0);
    for (int i = 0; i < 80; i++) begin
      issue(enc(OPR, 5, 0, 0), 1'b1, 4, w);
      issue(enc(BR, 0, 5, 0), 1'b0, 0, w);
      if (i == 0) chk("beq after lat4", w, 4);
    end
    @(negedge clk);
    chk("stall_cycles saturated", sb.stall_cycles, 8'hFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
